// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, state type and output saturation for the
// 16-tap accelerometer FIR filter.
//   NUM_TAPS / DATA_W / COEF_W  fixed filter geometry
//   ACC_W                       accumulator width; holds 16 full-scale products
//   fir_state_t                 controller states
//   sat16()                     clamp a wide signed value to 16-bit signed
package fir_pkg;

    localparam int NUM_TAPS = 16;
    localparam int DATA_W   = 16;
    localparam int COEF_W   = 16;
    localparam int ACC_W    = 37;
    localparam int TAP_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 37'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -37'sd32768;

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: combinational multiply-accumulate step.
//   acc_in   signed accumulator value
//   data     signed sample
//   coeff    unsigned Q0.16 weight
//   acc_out  acc_in + signed(data) * unsigned(coeff)
module fir_mac
    import fir_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic signed [DATA_W-1:0] data,
    input  logic        [COEF_W-1:0] coeff,
    output logic signed [ACC_W-1:0]  acc_out
);

    localparam int PROD_W = DATA_W + COEF_W + 1;

    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] coeff_ext;
    logic signed [PROD_W-1:0] product;

    // The coefficient is zero-extended so the multiply stays signed while the
    // weight keeps its full unsigned range; 33 bits hold every product exactly.
    assign data_ext  = {{(PROD_W-DATA_W){data[DATA_W-1]}}, data};
    assign coeff_ext = {{(PROD_W-COEF_W){1'b0}}, coeff};
    assign product   = data_ext * coeff_ext;
    assign acc_out   = acc_in + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

endmodule

// File: rtl/fir_16_tap.sv
// fir_16_tap: sequential 16-tap FIR, one multiply-accumulate per clock.
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   run          start strobe, honoured only while idle
//   busy         high from the accepting edge until the result is written
//   sample_in    signed sample, shifted into the delay line on accept
//   filter_data  last saturated result, held between computations
//   coeff0..15   unsigned Q0.16 tap weights, coeff0 weights the newest sample
module fir_16_tap
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    output logic                     busy,
    input  logic signed [DATA_W-1:0] sample_in,
    output logic signed [DATA_W-1:0] filter_data,
    input  logic        [COEF_W-1:0] coeff0,
    input  logic        [COEF_W-1:0] coeff1,
    input  logic        [COEF_W-1:0] coeff2,
    input  logic        [COEF_W-1:0] coeff3,
    input  logic        [COEF_W-1:0] coeff4,
    input  logic        [COEF_W-1:0] coeff5,
    input  logic        [COEF_W-1:0] coeff6,
    input  logic        [COEF_W-1:0] coeff7,
    input  logic        [COEF_W-1:0] coeff8,
    input  logic        [COEF_W-1:0] coeff9,
    input  logic        [COEF_W-1:0] coeff10,
    input  logic        [COEF_W-1:0] coeff11,
    input  logic        [COEF_W-1:0] coeff12,
    input  logic        [COEF_W-1:0] coeff13,
    input  logic        [COEF_W-1:0] coeff14,
    input  logic        [COEF_W-1:0] coeff15
);

    fir_state_t               state_reg;
    logic [TAP_W-1:0]         tap_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     busy_reg;
    logic signed [DATA_W-1:0] filter_data_reg;
    logic signed [DATA_W-1:0] dly_reg [NUM_TAPS];
    logic        [COEF_W-1:0] coeff_arr [NUM_TAPS];
    logic                     shift_en;

    assign coeff_arr[0]  = coeff0;
    assign coeff_arr[1]  = coeff1;
    assign coeff_arr[2]  = coeff2;
    assign coeff_arr[3]  = coeff3;
    assign coeff_arr[4]  = coeff4;
    assign coeff_arr[5]  = coeff5;
    assign coeff_arr[6]  = coeff6;
    assign coeff_arr[7]  = coeff7;
    assign coeff_arr[8]  = coeff8;
    assign coeff_arr[9]  = coeff9;
    assign coeff_arr[10] = coeff10;
    assign coeff_arr[11] = coeff11;
    assign coeff_arr[12] = coeff12;
    assign coeff_arr[13] = coeff13;
    assign coeff_arr[14] = coeff14;
    assign coeff_arr[15] = coeff15;

    // A run arriving in MAC or DONE must neither shift nor restart.
    assign shift_en = (state_reg == IDLE) && run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                dly_reg[k] <= '0;
            end
        end else if (shift_en) begin
            for (int k = NUM_TAPS-1; k > 0; k--) begin
                dly_reg[k] <= dly_reg[k-1];
            end
            dly_reg[0] <= sample_in;
        end
    end

    // Tap index selects both the delay-line entry and its live coefficient.
    fir_mac u_mac (
        .acc_in  (acc_reg),
        .data    (dly_reg[tap_reg]),
        .coeff   (coeff_arr[tap_reg]),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            tap_reg         <= '0;
            acc_reg         <= '0;
            busy_reg        <= 1'b0;
            filter_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (run) begin
                        state_reg <= MAC;
                        tap_reg   <= '0;
                        acc_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                MAC: begin
                    acc_reg <= acc_next;
                    // Wraps 15 -> 0 as the last tap is accumulated.
                    tap_reg <= tap_reg + 4'd1;
                    if (tap_reg == 4'(NUM_TAPS-1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // Arithmetic shift floors toward minus infinity (Q0.16 scaling).
                    filter_data_reg <= sat16(acc_reg >>> COEF_W);
                    busy_reg        <= 1'b0;
                    state_reg       <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign filter_data = filter_data_reg;

endmodule

// File: tb/tb_fir_16_tap.sv
module tb_fir_16_tap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] sample_in;
    logic [15:0] coeff [16];
    wire         busy;
    wire  [15:0] filter_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_16_tap dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .busy        (busy),
        .sample_in   (sample_in),
        .filter_data (filter_data),
        .coeff0      (coeff[0]),
        .coeff1      (coeff[1]),
        .coeff2      (coeff[2]),
        .coeff3      (coeff[3]),
        .coeff4      (coeff[4]),
        .coeff5      (coeff[5]),
        .coeff6      (coeff[6]),
        .coeff7      (coeff[7]),
        .coeff8      (coeff[8]),
        .coeff9      (coeff[9]),
        .coeff10     (coeff[10]),
        .coeff11     (coeff[11]),
        .coeff12     (coeff[12]),
        .coeff13     (coeff[13]),
        .coeff14     (coeff[14]),
        .coeff15     (coeff[15])
    );

    // ---------------- behavioural reference ----------------
    // Sample history plus a countdown of cycles until the result appears.
    logic [15:0] m_hist [16];
    logic        m_busy;
    int          m_cnt;
    logic [15:0] m_fd;
    logic [15:0] m_pend;

    // Weighted sum of the window that results from pushing `newest`.
    function automatic logic [15:0] model_result(input logic [15:0] newest);
        longint sum;
        logic [15:0] d;
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            d = (i == 0) ? newest : m_hist[i-1];
            sum += longint'($signed(d)) * longint'(coeff[i]);
        end
        sum = sum >>> 16;
        if (sum > 32767)       return 16'h7FFF;
        else if (sum < -32768) return 16'h8000;
        else                   return sum[15:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) m_hist[k] <= '0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_fd   <= '0;
            m_pend <= '0;
        end else if (!m_busy) begin
            if (run) begin
                for (int k = 1; k < 16; k++) m_hist[k] <= m_hist[k-1];
                m_hist[0] <= sample_in;
                m_pend    <= model_result(sample_in);
                m_busy    <= 1'b1;
                m_cnt     <= 17;
            end
        end else begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_fd   <= m_pend;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
        check("cyc_data", {16'd0, filter_data}, {16'd0, m_fd});
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_run(input logic [15:0] s, input bit chk, input logic [15:0] exp,
                          input string name, input bit glitch, input logic [15:0] gs);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_idle_wait: busy stuck at 1, required 0", name);
        end
        run       = 1'b1;
        sample_in = s;
        @(negedge clk);
        run = 1'b0;
        check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (glitch && n == 5) begin
                run       = 1'b1;
                sample_in = gs;
            end else begin
                run = 1'b0;
            end
            @(negedge clk);
        end
        run = 1'b0;
        check({name, "_busy_len"}, n, 32'd17);
        if (chk) check({name, "_result"}, {16'd0, filter_data}, {16'd0, exp});
        $display("[TB] run %s sample=%h result=%h busy_cycles=%0d", name, s, filter_data, n);
    endtask

    task automatic set_all(input logic [15:0] c);
        for (int i = 0; i < 16; i++) coeff[i] = c;
    endtask

    task automatic set_identity();
        set_all(16'h0000);
        coeff[0] = 16'hFFFF;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) coeff[i] = 16'($urandom);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        sample_in = '0;
        set_all(16'h0000);
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_data", {16'd0, filter_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity bank: output is the newest sample scaled by 65535/65536, floored.
        set_identity();
        do_run(16'h4000, 1, 16'h3FFF, "id_pos", 0, 0);
        do_run(16'hC000, 1, 16'hC000, "id_neg", 0, 0);

        // Reset in the middle of a computation.
        run       = 1'b1;
        sample_in = 16'd5;
        @(negedge clk);
        run = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midmac_rst_busy", {31'd0, busy}, 32'd0);
        check("midmac_rst_data", {16'd0, filter_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_run(16'd100, 1, 16'd99, "after_rst", 0, 0);

        // Moving average over a constant input.
        pulse_reset();
        set_all(16'h1000);
        for (int k = 1; k <= 17; k++) begin
            if (k == 1)       do_run(16'd1000, 1, 16'd62,   "mavg", 0, 0);
            else if (k == 2)  do_run(16'd1000, 1, 16'd125,  "mavg", 0, 0);
            else if (k == 3)  do_run(16'd1000, 1, 16'd187,  "mavg", 0, 0);
            else if (k >= 16) do_run(16'd1000, 1, 16'd1000, "mavg", 0, 0);
            else              do_run(16'd1000, 0, 16'd0,    "mavg", 0, 0);
        end

        // Saturation at both rails.
        set_all(16'hFFFF);
        for (int k = 1; k <= 16; k++) do_run(16'h7FFF, k == 16, 16'h7FFF, "sat_pos", 0, 0);
        for (int k = 1; k <= 16; k++) do_run(16'h8000, k == 16, 16'h8000, "sat_neg", 0, 0);

        // A run while busy must not shift a second sample in.
        pulse_reset();
        set_identity();
        do_run(16'd1234, 1, 16'd1233, "ignore_run", 1, 16'hFFF9);
        set_all(16'h0000);
        coeff[1] = 16'hFFFF;
        do_run(16'd0, 1, 16'd1233, "no_shift", 0, 0);

        // Back-to-back runs with weights on every tap.
        set_random();
        for (int k = 0; k < 4; k++) do_run(16'($urandom), 0, 16'd0, "b2b", 0, 0);

        // Randomised traffic; weights only change while idle.
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 0) set_random();
            do_run(16'($urandom), 0, 16'd0, "rand", 0, 0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
